// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//
// Sums a fixed number of unsigned 64-bit products from an upstream
// multiplier, then holds the result until a consumer takes it.
//
// The accepted start samples count. Each product that arrives with valid_in
// high is added to sum. Gaps of any length between products are allowed.
// After the last product the result is offered with valid_out. It stays
// stable until ready_in is seen.
//
// Configuration macro:
//   MAC_SATURATE_EN  If defined, a carry out of bit 63 clamps sum to all ones.
//                    If undefined (the default), sum wraps modulo 2^64.
//                    In both builds the sticky overflow flag is set.
//
// Ports:
//   clk        in   single clock; every state change is on its rising edge
//   reset      in   synchronous, active-high reset
//   start      in   begin a new accumulation; accepted only in IDLE
//   count      in   [COUNT_WIDTH] number of products; sampled with start
//   valid_in   in   a product is present on product this cycle
//   product    in   [64] unsigned product from the multiplier
//   ready_in   in   consumer accepts the result
//   busy       out  high in ACCUM and DONE
//   valid_out  out  result valid; high only in DONE
//   sum        out  [64] accumulator contents
//   overflow   out  sticky carry-out-of-bit-63 flag for this accumulation
// ---------------------------------------------------------------------------
module mac_accumulator #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   valid_in,
    input  logic [63:0]            product,
    input  logic                   ready_in,
    output logic                   busy,
    output logic                   valid_out,
    output logic [63:0]            sum,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] remaining;

    // Adder with the carry kept as a 65th bit
    logic [64:0] sum_ext;
    logic        carry;
    logic [63:0] next_sum;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sum_ext  = {1'b0, sum} + {1'b0, product};
        carry    = sum_ext[64];
        next_sum = sum_ext[63:0];
`ifdef MAC_SATURATE_EN
        // Clamp on carry. When sum is all ones, any nonzero product carries
        // again, so sum stays pinned for the rest of the run.
        if (carry) begin
            next_sum = '1;
        end
`endif
    end

    // busy and valid_out are registered along with the state. They change
    // on the same edge as the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            sum       <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (count != '0) begin
                            remaining <= count;
                            state     <= ACCUM;
                        end else begin
                            // An empty accumulation completes at once
                            // with a zero result.
                            remaining <= '0;
                            valid_out <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    if (valid_in) begin
                        sum       <= next_sum;
                        remaining <= remaining - COUNT_WIDTH'(1);
                        if (carry) begin
                            overflow <= 1'b1;
                        end
                        if (remaining == COUNT_WIDTH'(1)) begin
                            valid_out <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    // sum and overflow are left untouched here. They stay
                    // visible in IDLE until the next accepted start.
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
//
// Directed test of mac_accumulator. Inputs change 1 ns after a rising edge.
// Outputs are checked at the same point, well away from the next edge.
// Define MAC_SATURATE_EN for both the bench and the RTL to test the
// saturating build.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] count;
    logic          valid_in;
    logic [63:0]   product;
    logic          ready_in;
    logic          busy;
    logic          valid_out;
    logic [63:0]   sum;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    mac_accumulator #(.COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .valid_in  (valid_in),
        .product   (product),
        .ready_in  (ready_in),
        .busy      (busy),
        .valid_out (valid_out),
        .sum       (sum),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all four outputs at once
    task automatic check_all(input string tag, input logic exp_busy, input logic exp_vo,
                             input logic [63:0] exp_sum, input logic exp_ovf);
        check1 ({tag, ".busy"},      busy,      exp_busy);
        check1 ({tag, ".valid_out"}, valid_out, exp_vo);
        check64({tag, ".sum"},       sum,       exp_sum);
        check1 ({tag, ".overflow"},  overflow,  exp_ovf);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        count    = '0;
        valid_in = 1'b0;
        product  = '0;
        ready_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_all("reset", 1'b0, 1'b0, 64'd0, 1'b0);

        // V1: count=3, products 2,3,4 back to back -> 9
        start = 1'b1; count = 16'd3;
        tick();
        start = 1'b0;
        check_all("v1_start", 1'b1, 1'b0, 64'd0, 1'b0);
        valid_in = 1'b1; product = 64'd2; tick();
        product = 64'd3; tick();
        check_all("v1_mid", 1'b1, 1'b0, 64'd5, 1'b0);
        product = 64'd4; tick();
        valid_in = 1'b0;
        check_all("v1_done", 1'b1, 1'b1, 64'd9, 1'b0);
        ready_in = 1'b1; tick();
        ready_in = 1'b0;
        check_all("v1_idle", 1'b0, 1'b0, 64'd9, 1'b0);
        // valid_in is ignored in IDLE
        valid_in = 1'b1; product = 64'd100; tick();
        valid_in = 1'b0;
        check_all("idle_ignore_valid", 1'b0, 1'b0, 64'd9, 1'b0);

        // V2: count=0 -> DONE next cycle with zero result
        start = 1'b1; count = 16'd0;
        tick();
        check_all("v2_done", 1'b1, 1'b1, 64'd0, 1'b0);
        // start is held high through the handshake cycle and must be ignored
        count = 16'd5; ready_in = 1'b1;
        tick();
        start = 1'b0; ready_in = 1'b0;
        check_all("v2_idle", 1'b0, 1'b0, 64'd0, 1'b0);
        tick();
        check_all("v2_no_restart", 1'b0, 1'b0, 64'd0, 1'b0);

        // V3: all ones + 2 -> carry out of bit 63
        start = 1'b1; count = 16'd2;
        tick();
        start = 1'b0;
        valid_in = 1'b1; product = ALL_ONES; tick();
        check_all("v3_first", 1'b1, 1'b0, ALL_ONES, 1'b0);
        product = 64'd2; tick();
        valid_in = 1'b0;
`ifdef MAC_SATURATE_EN
        check_all("v3_done", 1'b1, 1'b1, ALL_ONES, 1'b1);
`else
        check_all("v3_done", 1'b1, 1'b1, 64'd1, 1'b1);
`endif
        ready_in = 1'b1; tick();
        ready_in = 1'b0;
        // overflow stays set in IDLE until the next accepted start
        check1("v3_idle.overflow", overflow, 1'b1);

        // V4: 5, three idle cycles, 7; consumer stalls for 5 cycles
        start = 1'b1; count = 16'd2;
        tick();
        start = 1'b0;
        check_all("v4_start_clears", 1'b1, 1'b0, 64'd0, 1'b0);
        valid_in = 1'b1; product = 64'd5; tick();
        valid_in = 1'b0;
        tick(); tick(); tick();
        check_all("v4_gap", 1'b1, 1'b0, 64'd5, 1'b0);
        valid_in = 1'b1; product = 64'd7; tick();
        // Keep products arriving in DONE; they must be ignored
        product = 64'd1;
        for (int i = 0; i < 5; i++) begin
            check_all($sformatf("v4_stall%0d", i), 1'b1, 1'b1, 64'd12, 1'b0);
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1; tick();
        ready_in = 1'b0;
        check_all("v4_idle", 1'b0, 1'b0, 64'd12, 1'b0);

        // V5: reset after one product discards the partial sum
        start = 1'b1; count = 16'd4;
        tick();
        start = 1'b0;
        valid_in = 1'b1; product = 64'd3; tick();
        valid_in = 1'b0;
        check_all("v5_partial", 1'b1, 1'b0, 64'd3, 1'b0);
        reset = 1'b1; tick();
        reset = 1'b0;
        check_all("v5_reset", 1'b0, 1'b0, 64'd0, 1'b0);
        start = 1'b1; count = 16'd1;
        tick();
        start = 1'b0;
        valid_in = 1'b1; product = 64'd6; tick();
        valid_in = 1'b0;
        check_all("v5_done", 1'b1, 1'b1, 64'd6, 1'b0);
        ready_in = 1'b1; tick();
        ready_in = 1'b0;

        // V6: start with count=9 during ACCUM is ignored
        start = 1'b1; count = 16'd2;
        tick();
        count = 16'd9;
        valid_in = 1'b1; product = 64'd1; tick();
        tick();
        start = 1'b0; valid_in = 1'b0;
        check_all("v6_done", 1'b1, 1'b1, 64'd2, 1'b0);

        // Reset in DONE returns to the reset state
        reset = 1'b1; tick();
        reset = 1'b0;
        check_all("done_reset", 1'b0, 1'b0, 64'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the product-count input.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a new accumulation; accepted only in IDLE.
REQ-005 SHALL have port count  input  COUNT_WIDTH  number of products to accumulate; sampled when start is accepted.
REQ-006 SHALL have port valid_in  input  1  a product is present on product this cycle (driven by the multiplier's valid_out).
REQ-007 SHALL have port product  input  64  unsigned product from the multiplier's r output.
REQ-008 SHALL have port ready_in  input  1  consumer accepts the result.
REQ-009 SHALL have port busy  output  1  high in ACCUM and DONE.
REQ-010 SHALL have port valid_out  output  1  result valid; high only in DONE.
REQ-011 SHALL have port sum  output  64  accumulator register contents.
REQ-012 SHALL have port overflow  output  1  sticky flag; set on carry out of bit 63 during the current accumulation.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ACCUM and DONE.
REQ-014 In IDLE with start=1 and count!=0, SHALL clear sum and overflow, load remaining=count, and enter ACCUM next cycle.
REQ-015 In IDLE with start=1 and count=0, SHALL clear sum and overflow and enter DONE next cycle.
REQ-016 SHALL ignore start in ACCUM and DONE, including in the DONE handshake cycle.
REQ-017 In ACCUM with valid_in=1, SHALL set sum<=sum+product (64-bit unsigned) and decrement remaining.
REQ-018 In ACCUM with valid_in=0, SHALL hold all state; gaps of any length SHALL be tolerated.
REQ-019 SHALL enter DONE on the cycle after accepting the product that makes remaining equal 1->0; valid_out SHALL rise one cycle after the last accepted product.
REQ-020 SHALL ignore valid_in in IDLE and DONE.
REQ-021 In DONE, sum and overflow SHALL be held stable until valid_out&&ready_in.
REQ-022 When valid_out&&ready_in, SHALL return to IDLE next cycle with valid_out=0 and busy=0; sum and overflow SHALL retain their values until the next accepted start.
REQ-023 SHALL set overflow (sticky) when an addition carries out of bit 63; overflow SHALL be cleared only by reset or an accepted start.

Reset
REQ-024 With reset=1 at a clock edge, SHALL enter IDLE with busy=0, valid_out=0, sum=0, overflow=0, remaining=0.
REQ-025 Reset SHALL take priority over every other input, including mid-ACCUM and mid-DONE; a partial accumulation SHALL be discarded.

Configuration
REQ-026 Macro MAC_SATURATE_EN SHALL select saturating accumulation.
REQ-027 Without MAC_SATURATE_EN, sum SHALL wrap modulo 2^64 on carry out of bit 63.
REQ-028 With MAC_SATURATE_EN, a carry out of bit 63 SHALL clamp sum to 0xFFFF_FFFF_FFFF_FFFF; sum SHALL stay at that value for the remaining products; overflow SHALL be set as in REQ-023.

Verification
REQ-029 V1: start with count=3, products 2,3,4 on consecutive cycles -> valid_out=1 one cycle after product 4, sum=9, overflow=0.
REQ-030 V2: start with count=0 -> next cycle valid_out=1, sum=0, overflow=0, busy=1.
REQ-031 V3: count=2, products 0xFFFF_FFFF_FFFF_FFFF then 2 -> without macro sum=1, overflow=1; with MAC_SATURATE_EN sum=0xFFFF_FFFF_FFFF_FFFF, overflow=1.
REQ-032 V4: count=2, products 5 and 7 with 3 idle cycles between, ready_in=0 for 5 cycles in DONE -> sum=12 held stable and valid_out held high throughout; on ready_in=1 -> IDLE next cycle, valid_out=0, sum stays 12.
REQ-033 V5: count=4, reset after 1 product accepted -> next cycle busy=0, sum=0; a new start with count=1 and product 6 -> sum=6.
REQ-034 V6: start=1 with count=9 asserted during ACCUM of count=2 (products 1,1) -> ignored; result sum=2 after exactly 2 products.
